// File: rtl/e1of4_pkg.sv
// Shared codes, FSM state type and 1-of-N helpers for the clocked e1of4 register.
package e1of4_pkg;

  localparam logic [2:0] CTRL_READ  = 3'b001;
  localparam logic [2:0] CTRL_WRITE = 3'b010;
  localparam logic [2:0] CTRL_RW    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_OUT,
    ST_OUT_ACK,
    ST_RTZ
  } state_e;

  function automatic logic [3:0] onehot4_encode(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  function automatic logic [1:0] onehot4_decode(input logic [3:0] x);
    logic [1:0] v;
    v = 2'd0;
    case (x)
      4'b0010: v = 2'd1;
      4'b0100: v = 2'd2;
      4'b1000: v = 2'd3;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  // 3-bit control codes are passed zero-extended.
  function automatic logic is_onehot(input logic [3:0] x);
    return (x != 4'b0000) && ((x & (x - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic is_neutral(input logic [3:0] x);
    return x == 4'b0000;
  endfunction

endpackage

// File: rtl/e1of4_sync.sv
// Per-bit multi-flop synchronizer with async active-low clear.
module e1of4_sync #(
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/e1of4_register_clocked.sv
// Single-clock e1of4 register responder: synchronized 4-phase handshakes on
// control, data and read channels around one 2-bit stored value.
module e1of4_register_clocked
  import e1of4_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] INIT_VAL    = 2'b00
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] Dx,
  output logic       Dxe,
  input  logic [2:0] Cx,
  output logic       Cxe,
  output logic [3:0] Rx,
  input  logic       Rxe,
  output logic       ERR
);

  logic [3:0] dx_s;
  logic [2:0] cx_s;
  logic       rxe_s;

  e1of4_sync #(.W(4), .SYNC_STAGES(SYNC_STAGES)) u_sync_dx (
    .clk(CLK), .rst_n(RESET), .d_i(Dx), .q_o(dx_s)
  );
  e1of4_sync #(.W(3), .SYNC_STAGES(SYNC_STAGES)) u_sync_cx (
    .clk(CLK), .rst_n(RESET), .d_i(Cx), .q_o(cx_s)
  );
  e1of4_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_rxe (
    .clk(CLK), .rst_n(RESET), .d_i(Rxe), .q_o(rxe_s)
  );

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] dat_q, dat_d;
  logic [1:0] val_q, val_d;
  logic       cxe_q, cxe_d;
  logic       dxe_q, dxe_d;
  logic [3:0] rx_q, rx_d;
  logic       err_q, err_d;

  logic cx_hot, cx_bad, dx_hot, dx_bad;
  assign cx_hot = is_onehot({1'b0, cx_s});
  assign cx_bad = !cx_hot && !is_neutral({1'b0, cx_s});
  assign dx_hot = is_onehot(dx_s);
  assign dx_bad = !dx_hot && !is_neutral(dx_s);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      dat_q   <= 2'd0;
      val_q   <= INIT_VAL;
      cxe_q   <= 1'b1;
      dxe_q   <= 1'b1;
      rx_q    <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dat_q   <= dat_d;
      val_q   <= val_d;
      cxe_q   <= cxe_d;
      dxe_q   <= dxe_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cx_hot) state_d = (cx_s == CTRL_READ) ? ST_OUT : ST_DATA;
      ST_DATA:    if (dx_hot) state_d = (op_q == CTRL_WRITE) ? ST_RTZ : ST_OUT;
      ST_OUT:     if (rxe_s)  state_d = ST_OUT_ACK;
      ST_OUT_ACK: if (!rxe_s) state_d = ST_RTZ;
      ST_RTZ:     if (cxe_q && dxe_q) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and datapath; multi-hot codes only set ERR and hold.
  always_comb begin
    op_d  = op_q;
    dat_d = dat_q;
    val_d = val_q;
    cxe_d = cxe_q;
    dxe_d = dxe_q;
    rx_d  = rx_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cx_hot) begin
          op_d  = cx_s;
          cxe_d = 1'b0;
        end else if (cx_bad) begin
          err_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (dx_hot) begin
          dat_d = onehot4_decode(dx_s);
          dxe_d = 1'b0;
          if (op_q == CTRL_WRITE) val_d = onehot4_decode(dx_s);
        end else if (dx_bad) begin
          err_d = 1'b1;
        end
      end
      ST_OUT: begin
        if (rxe_s) rx_d = onehot4_encode(val_q);
      end
      ST_OUT_ACK: begin
        if (!rxe_s) begin
          rx_d = 4'b0000;
          // READ+WRITE has already returned the old value, so commit now.
          if (op_q == CTRL_RW) val_d = dat_q;
        end
      end
      ST_RTZ: begin
        if (is_neutral({1'b0, cx_s})) cxe_d = 1'b1;
        if (is_neutral(dx_s))         dxe_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign Cxe = cxe_q;
  assign Dxe = dxe_q;
  assign Rx  = rx_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_e1of4_register_clocked.sv
// Directed bench for the clocked e1of4 register: handshakes, R+W ordering, errors, reset.
module tb_e1of4_register_clocked;

  localparam int         SYNC_STAGES = 2;
  localparam logic [1:0] INIT_VAL    = 2'b00;
  localparam int S_CXE = 0, S_DXE = 1, S_RX = 2, S_ERR = 3;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] Dx;
  logic       Dxe;
  logic [2:0] Cx;
  logic       Cxe;
  logic [3:0] Rx;
  logic       Rxe;
  logic       ERR;

  int checks   = 0;
  int failures = 0;

  e1of4_register_clocked #(.SYNC_STAGES(SYNC_STAGES), .INIT_VAL(INIT_VAL)) dut (
    .CLK(CLK), .RESET(RESET), .Dx(Dx), .Dxe(Dxe), .Cx(Cx), .Cxe(Cxe),
    .Rx(Rx), .Rxe(Rxe), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sig(input int w);
    case (w)
      S_CXE:   return {3'b000, Cxe};
      S_DXE:   return {3'b000, Dxe};
      S_RX:    return Rx;
      default: return {3'b000, ERR};
    endcase
  endfunction

  // Bounded wait; the final compare doubles as the timeout report.
  task automatic wait_for(input string tag, input int w, input logic [3:0] v);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (sig(w) === v) break;
    end
    chk(tag, sig(w), v);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0; Cx = 3'b000; Dx = 4'b0000; Rxe = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic read_op(input string tag, input logic [3:0] exp);
    wait_for({tag, "_cxe_idle"}, S_CXE, 4'd1);
    Cx = 3'b001;
    repeat (SYNC_STAGES) @(negedge CLK);
    chk({tag, "_cxe_hold"}, sig(S_CXE), 4'd1);
    @(negedge CLK);
    chk({tag, "_cxe_fall"}, sig(S_CXE), 4'd0);
    Cx = 3'b000;
    wait_for({tag, "_rx"}, S_RX, exp);
    chk({tag, "_dxe"}, sig(S_DXE), 4'd1);
    Rxe = 1'b0;
    wait_for({tag, "_rx_rtz"}, S_RX, 4'b0000);
    Rxe = 1'b1;
    wait_for({tag, "_cxe_rise"}, S_CXE, 4'd1);
  endtask

  task automatic write_op(input string tag, input logic [3:0] d);
    wait_for({tag, "_cxe_idle"}, S_CXE, 4'd1);
    Cx = 3'b010;
    wait_for({tag, "_cxe_fall"}, S_CXE, 4'd0);
    Cx = 3'b000;
    repeat (5) @(negedge CLK);
    chk({tag, "_dxe_wait"}, sig(S_DXE), 4'd1);
    Dx = d;
    wait_for({tag, "_dxe_fall"}, S_DXE, 4'd0);
    Dx = 4'b0000;
    @(negedge CLK);
    chk({tag, "_dxe_low"}, sig(S_DXE), 4'd0);
    wait_for({tag, "_dxe_rise"}, S_DXE, 4'd1);
    wait_for({tag, "_cxe_rise"}, S_CXE, 4'd1);
  endtask

  task automatic rw_op(input string tag, input logic [3:0] d, input logic [3:0] exp_old);
    wait_for({tag, "_cxe_idle"}, S_CXE, 4'd1);
    Cx = 3'b100;
    wait_for({tag, "_cxe_fall"}, S_CXE, 4'd0);
    Cx = 3'b000;
    Dx = d;
    wait_for({tag, "_dxe_fall"}, S_DXE, 4'd0);
    Dx = 4'b0000;
    wait_for({tag, "_rx"}, S_RX, exp_old);
    Rxe = 1'b0;
    wait_for({tag, "_rx_rtz"}, S_RX, 4'b0000);
    Rxe = 1'b1;
    wait_for({tag, "_dxe_rise"}, S_DXE, 4'd1);
    wait_for({tag, "_cxe_rise"}, S_CXE, 4'd1);
  endtask

  initial begin
    RESET = 1'b0; Cx = 3'b000; Dx = 4'b0000; Rxe = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_cxe", sig(S_CXE), 4'd1);
    chk("rst_dxe", sig(S_DXE), 4'd1);
    chk("rst_rx",  sig(S_RX),  4'b0000);
    chk("rst_err", sig(S_ERR), 4'd0);
    RESET = 1'b1;
    @(negedge CLK);

    read_op("rd_init", 4'b0001);
    write_op("wr3", 4'b1000);
    read_op("rd3", 4'b1000);
    write_op("wr2", 4'b0100);
    rw_op("rw1", 4'b0010, 4'b0100);
    read_op("rd1", 4'b0010);

    // Receiver not ready: Rx must stay neutral, FSM parked in OUT.
    Rxe = 1'b0;
    wait_for("stall_cxe_idle", S_CXE, 4'd1);
    Cx = 3'b001;
    wait_for("stall_cxe_fall", S_CXE, 4'd0);
    Cx = 3'b000;
    repeat (20) @(negedge CLK);
    chk("stall_rx", sig(S_RX), 4'b0000);
    chk("stall_cxe", sig(S_CXE), 4'd0);
    Rxe = 1'b1;
    wait_for("stall_rx_go", S_RX, 4'b0010);
    Rxe = 1'b0;
    wait_for("stall_rx_rtz", S_RX, 4'b0000);
    Rxe = 1'b1;
    wait_for("stall_cxe_rise", S_CXE, 4'd1);

    // Multi-hot control code.
    repeat (3) @(negedge CLK);
    Cx = 3'b011;
    wait_for("err_set", S_ERR, 4'd1);
    repeat (5) @(negedge CLK);
    chk("err_cxe", sig(S_CXE), 4'd1);
    Cx = 3'b000;
    repeat (4) @(negedge CLK);
    write_op("err_wr3", 4'b1000);
    read_op("err_rd3", 4'b1000);
    chk("err_sticky", sig(S_ERR), 4'd1);
    do_reset();
    chk("err_clr", sig(S_ERR), 4'd0);

    // Reset in OUT_ACK with Rx driven.
    write_op("ra_wr2", 4'b0100);
    wait_for("ra_cxe_idle", S_CXE, 4'd1);
    Cx = 3'b001;
    wait_for("ra_cxe_fall", S_CXE, 4'd0);
    Cx = 3'b000;
    wait_for("ra_rx", S_RX, 4'b0100);
    #2 RESET = 1'b0;
    #1 chk("ra_rx_async", sig(S_RX), 4'b0000);
    chk("ra_cxe_async", sig(S_CXE), 4'd1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    read_op("ra_rd_init", 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e1of4_register_clocked.md
# e1of4_register_clocked

Clocked, synthesizable responder for the e1of4 register channel protocol. It accepts 1-of-3 control tokens (READ, WRITE, READ+WRITE) and 1-of-4 data tokens from an upstream sender, holds one 2-bit value, and emits 1-of-4 read tokens to a downstream receiver. It is the DUT-side counterpart of the register testbench and converters: it replaces the asynchronous register cell wherever a single-clock implementation is required. All channel inputs are asynchronous to CLK and are synchronized internally.

## Interface
- SYNC_STAGES, 2, synchronizer depth on every channel input bit; minimum 2.
- INIT_VAL, 2'b00, stored value after reset.
- CLK  input  1  sole clock; all state updates on rising edge.
- RESET  input  1  reset, asynchronous and active-low; asserted (0) forces reset values immediately.
- Dx  input  4  1-of-4 write data (one-hot = value 0..3; 0000 = neutral).
- Dxe  output  1  data-channel enable; high = ready for a data token.
- Cx  input  3  1-of-3 control: bit0 READ, bit1 WRITE, bit2 READ+WRITE; 000 = neutral.
- Cxe  output  1  control-channel enable.
- Rx  output  4  1-of-4 read data to downstream.
- Rxe  input  1  downstream enable; high = receiver ready.
- ERR  output  1  sticky protocol-error flag.

## Operation
- Four-phase enable handshake on every channel: token asserted while enable high -> enable falls -> token returns to neutral -> enable rises.
- FSM states: IDLE, DATA, OUT, OUT_ACK, RTZ. Stored value `val` is 2 bits.
- IDLE: Cxe=1, Dxe=1. Synchronized Cx one-hot -> latch op, Cxe<=0. READ -> OUT; WRITE or READ+WRITE -> DATA.
- DATA: wait for synchronized Dx one-hot -> latch d=decode(Dx), Dxe<=0. WRITE -> val<=d, go to RTZ. READ+WRITE -> OUT, with val unchanged.
- OUT: wait for synchronized Rxe=1 -> Rx<=onehot(val), go to OUT_ACK.
- OUT_ACK: wait for synchronized Rxe=0 -> Rx<=0000. READ+WRITE also commits val<=d in the same cycle. Go to RTZ.
- RTZ:
  - Raise Cxe in the cycle Cx_s==000.
  - Raise Dxe in the cycle Dx_s==0000; if Dxe is already 1, no wait.
  - Enter IDLE in the cycle both enables are 1.
- READ+WRITE returns the old value on Rx; the new value is visible to the next READ.
- Multi-hot Cx_s in IDLE, or multi-hot Dx_s in DATA:
  - ERR<=1; the code is ignored and the state holds.
  - ERR clears only on RESET.
- Tokens arriving while the channel enable is low are ignored: Cx changes outside IDLE/RTZ, Dx outside DATA/RTZ. No error is raised.
- Reset values:
  - Cxe=1, Dxe=1, Rx=0000, ERR=0.
  - val=INIT_VAL, state=IDLE.
  - Synchronizer flops cleared to 0.
- Reset mid-operation drops any in-flight token. Rx goes neutral asynchronously.

## Timing
- Input-to-observation latency is SYNC_STAGES cycles. All outputs are registered; outputs change 1 cycle after the synchronized input condition.
- Cx valid at pin -> Cxe falls after SYNC_STAGES+1 cycles.
- READ, minimum cycle count, with Rxe already high and data neutralized promptly:
  - IDLE->OUT: 1 cycle.
  - Rx valid: +1 cycle.
  - Rx neutral: SYNC_STAGES+1 cycles after Rxe falls at pin.
  - Cxe rises: SYNC_STAGES+1 cycles after Cx neutral at pin.
- Enables never rise before the corresponding input is sampled neutral. Rx never changes while Rxe_s is in the wrong phase.
- Back-to-back tokens are supported: a new Cx token may be presented as soon as Cxe rises.

## Structure
- Package e1of4_pkg contains:
  - Control code constants CTRL_READ=3'b001, CTRL_WRITE=3'b010, CTRL_RW=3'b100.
  - FSM state enum.
  - Functions onehot4_encode, onehot4_decode, is_onehot, is_neutral.
- Sub-module e1of4_sync: SYNC_STAGES-deep, per-bit, async-reset synchronizer. It is instantiated for Dx, Cx and Rxe.
- Top level holds the FSM, val, ERR and the output registers.

## Test plan
- Reset -> Cxe=1, Dxe=1, Rx=0000, ERR=0. Then READ -> Rx=0001 (INIT_VAL 0), completes, Cxe returns to 1.
- WRITE with Dx=1000, then READ -> Rx=1000. Dxe falls only after Dx is valid, and rises after Dx returns to 0000.
- val=2, READ+WRITE with Dx=0010 -> Rx=0100 (old value 2). A following READ -> Rx=0010 (value 1).
- READ with Rxe held low for 20 cycles -> Rx stays 0000 and state stays OUT. Rxe rises -> Rx=onehot(val).
- Cx=011 in IDLE -> ERR=1, Cxe stays 1, no state change. A subsequent valid WRITE/READ still works with ERR=1 held. RESET clears ERR.
- RESET asserted during OUT_ACK, with Rx driven -> Rx=0000 immediately, val=INIT_VAL. After release, the next READ returns INIT_VAL.
